// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM states, BCD digit type
// and the difficulty clamp applied to Hit operands.
package score_pkg;

    typedef enum logic [2:0] {
        IDLE,
        D0,
        D1,
        D2,
        D3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       DIGIT_MAX = 4'd9;
    localparam logic [3:0] DIFF_MIN  = 4'd1;
    localparam logic [3:0] DIFF_MAX  = 4'd8;

    function automatic logic [3:0] clamp_difficulty(input logic [3:0] diff);
        logic [3:0] result;
        result = diff;
        if (diff < DIFF_MIN) begin
            result = DIFF_MIN;
        end else if (diff > DIFF_MAX) begin
            result = DIFF_MAX;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_addsub.sv
// Single BCD digit add/subtract step with carry/borrow in and out.
// cout is the carry on add and the borrow on subtract.
module bcd_digit_addsub
    import score_pkg::*;
(
    input  bcd_t       digit,
    input  logic [3:0] op,
    input  logic       cin,
    input  logic       sub,
    output bcd_t       digit_out,
    output logic       cout
);

    logic [4:0] total;
    logic [4:0] need;

    always_comb begin
        total     = {1'b0, digit} + {1'b0, op} + {4'b0, cin};
        need      = {1'b0, op} + {4'b0, cin};
        digit_out = digit;
        cout      = 1'b0;
        if (sub) begin
            if ({1'b0, digit} < need) begin
                digit_out = 4'({1'b0, digit} + 5'd10 - need);
                cout      = 1'b1;
            end else begin
                digit_out = 4'({1'b0, digit} - need);
            end
        end else if (total > 5'(DIGIT_MAX)) begin
            digit_out = 4'(total - 5'd10);
            cout      = 1'b1;
        end else begin
            digit_out = total[3:0];
        end
    end

endmodule

// File: rtl/score_keeper.sv
// Four-digit BCD score accumulator: Hit adds the clamped difficulty, Miss
// subtracts a penalty; one digit per cycle, result committed atomically.
module score_keeper
    import score_pkg::*;
#(
    parameter int unsigned MISS_PENALTY = 1
) (
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       Clear,
    input  logic       Hit,
    input  logic       Miss,
    input  logic [3:0] Difficulty,
    output bcd_t       ScoreThousands,
    output bcd_t       ScoreHundreds,
    output bcd_t       ScoreTens,
    output bcd_t       ScoreOnes,
    output logic       Busy,
    output logic       Saturated,
    output logic       Dropped
);

    localparam logic [3:0] PENALTY = 4'(MISS_PENALTY);

    state_t     state, nextState;
    bcd_t [3:0] score, work, commitScore;
    logic [3:0] opReg, pendOp, evOp;
    logic       subReg, pendSub, pendValid, carry;
    logic       busyReg, satReg, dropReg;
    logic       ev, evSub, slotFree, directLoad, toPend, discard, dropNow, satSet;

    logic [1:0] idx;
    bcd_t       aluIn, aluOut;
    logic [3:0] aluOp;
    logic       aluCin, aluCout;

    // Hit wins when both arrive together; the Miss is reported via Dropped.
    assign ev    = Hit | Miss;
    assign evSub = ~Hit;
    assign evOp  = Hit ? clamp_difficulty(Difficulty) : PENALTY;

    always_comb begin
        idx = 2'd0;
        case (state)
            D1:      idx = 2'd1;
            D2:      idx = 2'd2;
            D3:      idx = 2'd3;
            default: idx = 2'd0;
        endcase
        aluIn  = work[idx];
        aluOp  = (state == D0) ? opReg : '0;
        aluCin = (state == D0) ? 1'b0 : carry;
    end

    bcd_digit_addsub u_alu (
        .digit     (aluIn),
        .op        (aluOp),
        .cin       (aluCin),
        .sub       (subReg),
        .digit_out (aluOut),
        .cout      (aluCout)
    );

    always_comb begin
        commitScore = {aluOut, work[2], work[1], work[0]};
        satSet      = 1'b0;
        if (aluCout) begin
            if (subReg) begin
                commitScore = '0;
            end else begin
                commitScore = {4{DIGIT_MAX}};
                satSet      = (state == D3);
            end
        end
    end

    // The D3 commit frees the slot in the same cycle, so an event arriving
    // then is never lost; with no pending work it starts immediately.
    always_comb begin
        slotFree   = !pendValid || (state == D3);
        directLoad = (state == D3) && !pendValid;
        toPend     = ev && (state != IDLE) && slotFree && !directLoad;
        discard    = ev && (state != IDLE) && !slotFree;
        dropNow    = (Hit && Miss) || discard;
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (ev) nextState = D0;
            D0:      nextState = D1;
            D1:      nextState = D2;
            D2:      nextState = D3;
            D3:      nextState = (pendValid || ev) ? D0 : IDLE;
            default: nextState = IDLE;
        endcase
        if (Clear) begin
            nextState = IDLE;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            score     <= '0;
            work      <= '0;
            opReg     <= '0;
            subReg    <= 1'b0;
            carry     <= 1'b0;
            pendValid <= 1'b0;
            pendOp    <= '0;
            pendSub   <= 1'b0;
            busyReg   <= 1'b0;
            satReg    <= 1'b0;
            dropReg   <= 1'b0;
        end else if (Clear) begin
            score     <= '0;
            pendValid <= 1'b0;
            busyReg   <= 1'b0;
            satReg    <= 1'b0;
            dropReg   <= 1'b0;
        end else begin
            busyReg <= (nextState != IDLE);
            dropReg <= dropNow;
            case (state)
                IDLE: begin
                    if (ev) begin
                        work   <= score;
                        opReg  <= evOp;
                        subReg <= evSub;
                    end
                end
                D0, D1, D2: begin
                    work[idx] <= aluOut;
                    carry     <= aluCout;
                end
                D3: begin
                    score  <= commitScore;
                    satReg <= satReg | satSet;
                    if (pendValid) begin
                        work   <= commitScore;
                        opReg  <= pendOp;
                        subReg <= pendSub;
                    end else if (ev) begin
                        work   <= commitScore;
                        opReg  <= evOp;
                        subReg <= evSub;
                    end
                end
                default: ;
            endcase
            if (toPend) begin
                pendValid <= 1'b1;
                pendOp    <= evOp;
                pendSub   <= evSub;
            end else if (state == D3) begin
                pendValid <= 1'b0;
            end
        end
    end

    assign ScoreThousands = score[3];
    assign ScoreHundreds  = score[2];
    assign ScoreTens      = score[1];
    assign ScoreOnes      = score[0];
    assign Busy           = busyReg;
    assign Saturated      = satReg;
    assign Dropped        = dropReg;

endmodule

// File: tb/tb_score_keeper.sv
// Randomized and directed bench for score_keeper: the stimulus side predicts
// commit edges and values into a scoreboard, a negedge monitor compares.
module tb_score_keeper;
    import score_pkg::*;

    localparam int PEN = 1;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic       Clear = 1'b0;
    logic       Hit = 1'b0;
    logic       Miss = 1'b0;
    logic [3:0] Difficulty = 4'd0;
    bcd_t       ScoreThousands, ScoreHundreds, ScoreTens, ScoreOnes;
    logic       Busy, Saturated, Dropped;

    score_keeper #(.MISS_PENALTY(PEN)) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .Clear          (Clear),
        .Hit            (Hit),
        .Miss           (Miss),
        .Difficulty     (Difficulty),
        .ScoreThousands (ScoreThousands),
        .ScoreHundreds  (ScoreHundreds),
        .ScoreTens      (ScoreTens),
        .ScoreOnes      (ScoreOnes),
        .Busy           (Busy),
        .Saturated      (Saturated),
        .Dropped        (Dropped)
    );

    always #5 Clock = ~Clock;

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    typedef struct {
        int at;
        int score;
        bit sat;
    } exp_t;

    exp_t q[$];
    exp_t cur = '{0, 0, 1'b0};
    bit   busyAt[int];
    bit   dropAt[int];

    int mScore = 0;
    bit mSat = 1'b0;
    int lastCommit = -100;
    int checks = 0;
    int passed = 0;

    function automatic logic [15:0] toBcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Discard every prediction at or after edge e (Clear or reset wipes them).
    task automatic flush(input int e);
        while (q.size() > 0 && q[$].at >= e) void'(q.pop_back());
        for (int i = e; i < e + 16; i++) begin
            if (busyAt.exists(i)) busyAt.delete(i);
            if (dropAt.exists(i)) dropAt.delete(i);
        end
    endtask

    // Drive one cycle of inputs and predict its effect at the sampling edge.
    task automatic step(input bit h, input bit m, input bit c, input logic [3:0] d);
        int e, op, commitAt;
        bit drop;
        @(posedge Clock);
        #2;
        Hit = h;
        Miss = m;
        Clear = c;
        Difficulty = d;
        e = cyc + 1;
        if (c) begin
            flush(e);
            mScore = 0;
            mSat = 1'b0;
            lastCommit = -100;
            q.push_back('{e, 0, 1'b0});
        end else if (h || m) begin
            drop = h && m;
            if (lastCommit - 4 > e) begin
                drop = 1'b1;
            end else begin
                commitAt = ((e > lastCommit) ? e : lastCommit) + 4;
                if (h) begin
                    op = (d == 0) ? 1 : ((d > 8) ? 8 : int'(d));
                    if (mScore + op > 9999) begin
                        mScore = 9999;
                        mSat = 1'b1;
                    end else begin
                        mScore = mScore + op;
                    end
                end else begin
                    mScore = (mScore - PEN < 0) ? 0 : mScore - PEN;
                end
                q.push_back('{commitAt, mScore, mSat});
                for (int i = commitAt - 4; i < commitAt; i++) busyAt[i] = 1'b1;
                lastCommit = commitAt;
            end
            if (drop) dropAt[e] = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic hitWait(input logic [3:0] d);
        step(1'b1, 1'b0, 1'b0, d);
        idle(4);
    endtask

    task automatic missWait();
        step(1'b0, 1'b1, 1'b0, 4'd0);
        idle(4);
    endtask

    task automatic midReset();
        int e;
        @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        Hit = 1'b0;
        Miss = 1'b0;
        Clear = 1'b0;
        #1;
        chk("reset_score", int'({ScoreThousands, ScoreHundreds, ScoreTens, ScoreOnes}), 0);
        chk("reset_busy", int'(Busy), 0);
        chk("reset_saturated", int'(Saturated), 0);
        chk("reset_dropped", int'(Dropped), 0);
        e = cyc + 1;
        flush(e);
        mScore = 0;
        mSat = 1'b0;
        lastCommit = -100;
        q.push_back('{e, 0, 1'b0});
        repeat (2) @(posedge Clock);
        #2;
        Reset_n = 1'b1;
    endtask

    always @(negedge Clock) begin
        while (q.size() > 0 && q[0].at <= cyc) cur = q.pop_front();
        if (Reset_n) begin
            chk("score", int'({ScoreThousands, ScoreHundreds, ScoreTens, ScoreOnes}),
                int'(toBcd(cur.score)));
            chk("saturated", int'(Saturated), int'(cur.sat));
            chk("busy", int'(Busy), int'(busyAt.exists(cyc)));
            chk("dropped", int'(Dropped), int'(dropAt.exists(cyc)));
        end
    end

    initial begin
        int w;
        repeat (3) @(posedge Clock);
        #2;
        Reset_n = 1'b1;
        idle(2);

        // single Hit, 4-edge latency
        hitWait(4'd3);
        idle(2);

        // carry and borrow chains through 0099 / 0100
        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 12; i++) hitWait(4'd8);
        hitWait(4'd3);
        hitWait(4'd1);
        missWait();

        // saturation at 9999
        step(1'b0, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 1249; i++) hitWait(4'd8);
        hitWait(4'd3);
        hitWait(4'd8);
        hitWait(4'd8);
        step(1'b0, 1'b0, 1'b1, 4'd0);
        idle(2);

        // floor and operand clamping
        missWait();
        hitWait(4'd0);
        hitWait(4'd12);
        step(1'b1, 1'b1, 1'b0, 4'd5);
        idle(5);

        // pending slot and dropped event, then Clear aborting in flight work
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b1, 1'b0, 1'b0, 4'd2);
        idle(10);
        step(1'b0, 1'b0, 1'b1, 4'd0);
        step(1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b1, 1'b0, 1'b0, 4'd2);
        step(1'b0, 1'b0, 1'b1, 4'd0);
        idle(10);

        // event landing on the commit cycle
        hitWait(4'd1);
        step(1'b1, 1'b0, 1'b0, 4'd4);
        idle(3);
        step(1'b1, 1'b0, 1'b0, 4'd5);
        idle(10);

        for (int i = 0; i < 800; i++) begin
            step($urandom % 4 == 0, $urandom % 6 == 0, $urandom % 50 == 0, 4'($urandom % 16));
        end
        midReset();
        for (int i = 0; i < 300; i++) begin
            step($urandom % 3 == 0, $urandom % 5 == 0, $urandom % 60 == 0, 4'($urandom % 16));
        end
        idle(1);

        w = 0;
        while (q.size() > 0 && w < 100) begin
            @(posedge Clock);
            w++;
        end
        if (q.size() != 0) chk("drain", q.size(), 0);
        idle(2);
        @(posedge Clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
